gpr_wb_regfile: RTL and testbench



---
 rtl/gpr_wb_regfile.sv | 101 ++++++++++
 tb/tb_gpr_wb_regfile.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_regfile.sv
// General-purpose register file with write-back port, two read ports and a pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write-back data and busy clears to readers/issue.
module gpr_wb_regfile #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic                  wb_wen,
  input  logic [ADDR_WIDTH-1:0] wb_waddr,
  input  logic [DATA_WIDTH-1:0] wb_wdata,
  input  logic                  iss_valid,
  output logic                  iss_ready,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NREG];
  logic [DATA_WIDTH-1:0] regs_d [NREG];
  logic [NREG-1:0]       sb_q;
  logic [NREG-1:0]       sb_d;
  logic                  ready_q;
  logic                  ready_d;

  logic wb_fire;
  logic wb_commit;
  logic iss_fire;
  logic iss_clear_fwd;

  assign wb_ready  = ready_q;
  assign wb_fire   = wb_valid & wb_ready;
  assign wb_commit = wb_fire & wb_wen & (wb_waddr != '0);
  assign iss_fire  = iss_valid & iss_ready;

`ifdef REGFILE_BYPASS_EN
  assign iss_clear_fwd = wb_commit & (wb_waddr == iss_rd);
`else
  assign iss_clear_fwd = 1'b0;
`endif

  // ready_q holds both handshakes low until the first edge after reset release
  assign iss_ready = ready_q & (~sb_q[iss_rd] | (iss_rd == '0) | iss_clear_fwd);

  always_comb begin
    ready_d = 1'b1;
    regs_d  = regs_q;
    sb_d    = sb_q;
    if (wb_commit) begin
      regs_d[wb_waddr] = wb_wdata;
      sb_d[wb_waddr]   = 1'b0;
    end
    // issue set applied after the clear so it wins a same-register collision
    if (iss_fire && (iss_rd != '0)) begin
      sb_d[iss_rd] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q <= 1'b0;
      sb_q    <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      ready_q <= ready_d;
      sb_q    <= sb_d;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
    rs1_busy = sb_q[rs1_addr];
    rs2_busy = sb_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (wb_commit && (wb_waddr == rs1_addr)) begin
      rs1_data = wb_wdata;
      rs1_busy = 1'b0;
    end
    if (wb_commit && (wb_waddr == rs2_addr)) begin
      rs2_data = wb_wdata;
      rs2_busy = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_gpr_wb_regfile.sv
// Testbench for gpr_wb_regfile: directed vector table, hand sequences, and random traffic vs. an array model.
module tb_gpr_wb_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_valid = 1'b0, wb_wen = 1'b0, iss_valid = 1'b0;
  logic [4:0]  wb_waddr = '0, iss_rd = '0, rs1_addr = '0, rs2_addr = '0;
  logic [31:0] wb_wdata = '0;
  logic        wb_ready, iss_ready, rs1_busy, rs2_busy;
  logic [31:0] rs1_data, rs2_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  bit          m_sb   [32];

  gpr_wb_regfile #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wen(wb_wen),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wv, input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                       input logic iv, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2);
    wb_valid = wv; wb_wen = wen; wb_waddr = wa; wb_wdata = wd;
    iss_valid = iv; iss_rd = ird; rs1_addr = r1; rs2_addr = r2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  // Reference model: architectural state as plain arrays, outputs derived from the read/issue rules
  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (BYP && wb_valid && wb_wen && wb_waddr == a) return wb_wdata;
    return m_regs[a];
  endfunction

  function automatic logic m_busy(input logic [4:0] a);
    if (BYP && wb_valid && wb_wen && wb_waddr == a && a != 0) return 1'b0;
    return m_sb[a];
  endfunction

  function automatic logic m_iss_ready(input logic [4:0] rd);
    if (rd == 0 || !m_sb[rd]) return 1'b1;
    return BYP && wb_valid && wb_wen && wb_waddr == rd;
  endfunction

  task automatic m_commit();
    logic ir;
    ir = m_iss_ready(iss_rd);
    if (wb_valid && wb_wen && wb_waddr != 0) begin
      m_regs[wb_waddr] = wb_wdata;
      m_sb[wb_waddr]   = 1'b0;
    end
    if (iss_valid && ir && iss_rd != 0) m_sb[iss_rd] = 1'b1;
  endtask

  task automatic m_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_sb[i]   = 1'b0;
    end
  endtask

  typedef struct {
    logic        wv, wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  ird, r1, r2;
    logic [31:0] e1, e2;
    logic        eb1, eb2, eir;
  } vec_t;

  vec_t vt [8];

  initial begin
    // expected values describe state committed by earlier vectors; no same-cycle read of the write target
    vt[0] = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd1, 5'd2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1};
    vt[1] = '{1'b1, 1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b1};
    vt[2] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1};
    vt[3] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0};
    vt[4] = '{1'b1, 1'b1, 5'd7, 32'h00000055, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b1};
    vt[5] = '{1'b1, 1'b0, 5'd5, 32'hFFFFFFFF, 1'b0, 5'd7, 5'd7, 5'd0, 32'h55, 32'h0, 1'b0, 1'b0, 1'b1};
    vt[6] = '{1'b1, 1'b1, 5'd3, 32'h0000000A, 1'b1, 5'd3, 5'd6, 5'd5, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
    vt[7] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd3, 5'd5, 32'hA, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0};

    // Reset and release
    idle();
    #12;
    chk("wb_ready_in_reset", wb_ready, 1'b0);
    chk("iss_ready_in_reset", iss_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("wb_ready_after_reset", wb_ready, 1'b1);
    chk("iss_ready_after_reset", iss_ready, 1'b1);
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a);
      rs2_addr = 5'(31 - a);
      #1;
      chk($sformatf("reset_rs1_data[%0d]", a), rs1_data, 32'h0);
      chk($sformatf("reset_rs2_busy[%0d]", 31 - a), rs2_busy, 1'b0);
    end

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].wv, vt[i].wen, vt[i].wa, vt[i].wd, vt[i].iv, vt[i].ird, vt[i].r1, vt[i].r2);
      #1;
      chk($sformatf("vec%0d_rs1_data", i), rs1_data, vt[i].e1);
      chk($sformatf("vec%0d_rs2_data", i), rs2_data, vt[i].e2);
      chk($sformatf("vec%0d_rs1_busy", i), rs1_busy, vt[i].eb1);
      chk($sformatf("vec%0d_rs2_busy", i), rs2_busy, vt[i].eb2);
      chk($sformatf("vec%0d_iss_ready", i), iss_ready, vt[i].eir);
      step();
    end

    // Bypass sequence: producer outstanding on x9, write-back observed in the same cycle
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
    step();
    drive(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 5'd9, 5'd9, 5'd9);
    #1;
    chk("byp_rs1_data", rs1_data, BYP ? 32'h99 : 32'h0);
    chk("byp_rs2_busy", rs2_busy, BYP ? 1'b0 : 1'b1);
    chk("byp_iss_ready", iss_ready, BYP ? 1'b1 : 1'b0);
    step();
    idle();
    rs1_addr = 5'd9;
    #1;
    chk("byp_after_data", rs1_data, 32'h99);
    chk("byp_after_busy", rs1_busy, 1'b0);

    // Mid-run reset: x4 written then made busy, reset asserted between edges
    drive(1'b1, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 5'd4, 5'd4);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd4);
    step();
    idle();
    rs1_addr = 5'd4;
    rs2_addr = 5'd3;
    #1;
    chk("midrst_pre_data", rs1_data, 32'h44);
    chk("midrst_pre_busy", rs1_busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("midrst_data", rs1_data, 32'h0);
    chk("midrst_busy", rs1_busy, 1'b0);
    chk("midrst_rs2_data", rs2_data, 32'h0);
    chk("midrst_wb_ready", wb_ready, 1'b0);
    chk("midrst_iss_ready", iss_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("midrst_release_wb_ready", wb_ready, 1'b1);

    // Random traffic against the model
    m_clear();
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
            $urandom(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      #1;
      chk("rnd_wb_ready", wb_ready, 1'b1);
      chk("rnd_rs1_data", rs1_data, m_read(rs1_addr));
      chk("rnd_rs2_data", rs2_data, m_read(rs2_addr));
      chk("rnd_rs1_busy", rs1_busy, m_busy(rs1_addr));
      chk("rnd_rs2_busy", rs2_busy, m_busy(rs2_addr));
      chk("rnd_iss_ready", iss_ready, m_iss_ready(iss_rd));
      m_commit();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
